// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M execute unit: func3 codes, FSM state
// encoding and small func3 decode helpers.
package rv32m_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic f3_is_div(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic logic f3_signed_div(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  // rs1 is signed for everything except MULHU; rs2 only for MUL/MULH
  function automatic logic mul_a_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU);
  endfunction

  function automatic logic mul_b_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Issue/result bundle between the ID/EX pipeline register and the M-extension unit.
interface ex_muldiv_unit_if #(parameter int XLEN = 32);
  logic            Start;
  logic            Flush;
  logic [2:0]      Func3;
  logic [XLEN-1:0] Operand1;
  logic [XLEN-1:0] Operand2;
  logic [4:0]      WriteAddress;
  logic            Busy;
  logic            Stall;
  logic            Done;
  logic [XLEN-1:0] Result;
  logic [4:0]      Out_WriteAddress;

  modport master (
    output Start, Flush, Func3, Operand1, Operand2, WriteAddress,
    input  Busy, Stall, Done, Result, Out_WriteAddress
  );

  modport slave (
    input  Start, Flush, Func3, Operand1, Operand2, WriteAddress,
    output Busy, Stall, Done, Result, Out_WriteAddress
  );
endinterface

// File: rtl/rv32_div_iter.sv
// Radix-2 restoring divider datapath on unsigned magnitudes; one quotient bit per step.
module rv32_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);
  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] dvs_reg;
  logic [XLEN:0]   rem_reg;
  logic [CW-1:0]   count_reg;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // A borrow out of the trial subtraction lands in the top bit.
  always_comb begin
    shifted = (rem_reg << 1) | (XLEN+1)'(quo_reg[XLEN-1]);
    diff    = shifted - {1'b0, dvs_reg};
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      quo_reg   <= '0;
      dvs_reg   <= '0;
      rem_reg   <= '0;
      count_reg <= '0;
    end else if (start) begin
      quo_reg   <= dividend;
      dvs_reg   <= divisor;
      rem_reg   <= '0;
      count_reg <= CW'(XLEN-1);
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem_reg <= diff;
        quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
      end else begin
        rem_reg <= shifted;
        quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
      end
      count_reg <= count_reg - CW'(1);
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg[XLEN-1:0];
  assign last      = (count_reg == '0);
endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: 2-cycle multiplier, iterative divider, and pipeline stall
// generation while an operation is in flight.
module ex_muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  ex_muldiv_unit_if.slave  bus
);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_reg, state_next;
  logic [2:0]        func3_reg;
  logic [XLEN-1:0]   op1_reg, op2_reg;
  logic [4:0]        waddr_reg;
  logic [XLEN-1:0]   result_reg, result_next;
  logic [4:0]        out_waddr_reg, out_waddr_next;
  logic              load_result;

  logic              busy, accept, in_signed, in_special, div_start, div_step, div_last;
  logic [XLEN-1:0]   special_result, mag1, mag2;
  logic [XLEN-1:0]   div_quo, div_rem, fix_quo, fix_rem, fix_result, mul_result;
  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN+1:0] product;

  assign busy   = (state_reg == ST_MUL) || (state_reg == ST_DIV) || (state_reg == ST_FIX);
  assign accept = bus.Start && !busy && !bus.Flush;

  // Special divides are resolved straight from the incoming operands.
  always_comb begin
    in_signed  = f3_signed_div(bus.Func3);
    in_special = (bus.Operand2 == '0) ||
                 (in_signed && bus.Operand1 == MIN_NEG && bus.Operand2 == '1);
    if (bus.Operand2 == '0)
      special_result = f3_is_rem(bus.Func3) ? bus.Operand1 : '1;
    else
      special_result = f3_is_rem(bus.Func3) ? '0 : MIN_NEG;
    mag1 = (in_signed && bus.Operand1[XLEN-1]) ? -bus.Operand1 : bus.Operand1;
    mag2 = (in_signed && bus.Operand2[XLEN-1]) ? -bus.Operand2 : bus.Operand2;
  end

  always_comb begin
    mul_a      = {mul_a_signed(func3_reg) & op1_reg[XLEN-1], op1_reg};
    mul_b      = {mul_b_signed(func3_reg) & op2_reg[XLEN-1], op2_reg};
    product    = mul_a * mul_b;
    mul_result = XLEN'(product >> ((func3_reg == F3_MUL) ? 0 : XLEN));
  end

  // Sign restoration after magnitude division.
  always_comb begin
    fix_quo = (f3_signed_div(func3_reg) && (op1_reg[XLEN-1] ^ op2_reg[XLEN-1])) ? -div_quo : div_quo;
    fix_rem = (f3_signed_div(func3_reg) && op1_reg[XLEN-1]) ? -div_rem : div_rem;
    fix_result = f3_is_rem(func3_reg) ? fix_rem : fix_quo;
  end

  always_comb begin
    state_next     = state_reg;
    load_result    = 1'b0;
    result_next    = result_reg;
    out_waddr_next = out_waddr_reg;
    div_start      = 1'b0;
    div_step       = 1'b0;
    if (bus.Flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (bus.Start) begin
            if (!f3_is_div(bus.Func3)) begin
              state_next = ST_MUL;
            end else if (in_special) begin
              state_next     = ST_DONE;
              load_result    = 1'b1;
              result_next    = special_result;
              out_waddr_next = bus.WriteAddress;
            end else begin
              state_next = ST_DIV;
              div_start  = 1'b1;
            end
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_MUL: begin
          state_next     = ST_DONE;
          load_result    = 1'b1;
          result_next    = mul_result;
          out_waddr_next = waddr_reg;
        end
        ST_DIV: begin
          div_step = 1'b1;
          if (div_last) state_next = ST_FIX;
        end
        ST_FIX: begin
          state_next     = ST_DONE;
          load_result    = 1'b1;
          result_next    = fix_result;
          out_waddr_next = waddr_reg;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_reg     <= ST_IDLE;
      func3_reg     <= '0;
      op1_reg       <= '0;
      op2_reg       <= '0;
      waddr_reg     <= '0;
      result_reg    <= '0;
      out_waddr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        func3_reg <= bus.Func3;
        op1_reg   <= bus.Operand1;
        op2_reg   <= bus.Operand2;
        waddr_reg <= bus.WriteAddress;
      end
      if (load_result) begin
        result_reg    <= result_next;
        out_waddr_reg <= out_waddr_next;
      end
    end
  end

  rv32_div_iter #(.XLEN(XLEN)) u_div (
    .CLK       (CLK),
    .Reset     (Reset),
    .start     (div_start),
    .step      (div_step),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last      (div_last)
  );

  assign bus.Busy             = busy;
  assign bus.Stall            = busy || (accept && (state_next != ST_DONE));
  assign bus.Done             = (state_reg == ST_DONE);
  assign bus.Result           = result_reg;
  assign bus.Out_WriteAddress = out_waddr_reg;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed scoreboard bench for ex_muldiv_unit: issue pushes expectations, a
// negedge monitor checks each Done against them including completion cycle.
module tb_ex_muldiv_unit;
  import rv32m_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wa;
    int          cyc;
  } exp_t;

  logic CLK;
  logic Reset;
  int   cyc;
  int   checks;
  int   errors;
  int   done_count;
  logic [31:0] last_res;
  exp_t exp_q[$];

  ex_muldiv_unit_if #(.XLEN(32)) bus ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (Reset === 1'b1 && bus.Done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: Result 0x%08h with no op outstanding (cycle %0d)", bus.Result, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", bus.Result, e.res);
        chk("out_waddr", 32'(bus.Out_WriteAddress), 32'(e.wa));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        $display("done: cycle %0d Result 0x%08h rd %0d", cyc, bus.Result, bus.Out_WriteAddress);
        last_res = e.res;
      end
    end
  end

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa);
    bus.Start = 1'b1;
    bus.Func3 = f3;
    bus.Operand1 = a;
    bus.Operand2 = b;
    bus.WriteAddress = wa;
  endtask

  // Issue one op in the current cycle (cycle 0); returns at the next negedge with Start low.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic [31:0] exp, input int lat,
                       input bit track, output int s);
    @(negedge CLK);
    drive(f3, a, b, wa);
    s = cyc;
    if (track) exp_q.push_back('{exp, wa, cyc + lat});
    $display("issue: cycle %0d func3 %0d op1 0x%08h op2 0x%08h rd %0d", cyc, f3, a, b, wa);
    #1 chk("stall_c0", 32'(bus.Stall), (lat == 1) ? 32'd0 : 32'd1);
    @(negedge CLK);
    bus.Start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge CLK);
      #1 n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge CLK);
  endtask

  initial begin
    int s;
    int dc;
    cyc = 0; checks = 0; errors = 0; done_count = 0; last_res = '0;
    Reset = 1'b0;
    bus.Start = 1'b0; bus.Flush = 1'b0; bus.Func3 = '0;
    bus.Operand1 = '0; bus.Operand2 = '0; bus.WriteAddress = '0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_stall", 32'(bus.Stall), 32'd0);
    chk("rst_result", bus.Result, 32'd0);
    chk("rst_waddr", 32'(bus.Out_WriteAddress), 32'd0);
    @(negedge CLK);
    Reset = 1'b1;

    // MUL with stall profile across cycles 0..2
    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 2, 1'b1, s);
    #1 chk("mul_stall_c1", 32'(bus.Stall), 32'd1);
    chk("mul_busy_c1", 32'(bus.Busy), 32'd1);
    @(negedge CLK);
    #1 chk("mul_stall_c2", 32'(bus.Stall), 32'd0);
    chk("mul_busy_c2", 32'(bus.Busy), 32'd0);
    wait_idle();

    issue(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 2, 1'b1, s); wait_idle();
    issue(F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd7,  32'hFFFF_FFFF, 2, 1'b1, s); wait_idle();
    issue(F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd8,  32'h4000_0000, 2, 1'b1, s); wait_idle();
    issue(F3_DIV,    32'hFFFF_FFEC, 32'd3,         5'd9,  32'hFFFF_FFFA, 34, 1'b1, s); wait_idle();
    issue(F3_REM,    32'hFFFF_FFEC, 32'd3,         5'd10, 32'hFFFF_FFFE, 34, 1'b1, s); wait_idle();
    issue(F3_DIV,    32'd20,        32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFFA, 34, 1'b1, s); wait_idle();
    issue(F3_REM,    32'd20,        32'hFFFF_FFFD, 5'd12, 32'd2,         34, 1'b1, s); wait_idle();
    issue(F3_DIVU,   32'hFFFF_FFFF, 32'd16,        5'd13, 32'h0FFF_FFFF, 34, 1'b1, s); wait_idle();
    issue(F3_REMU,   32'hFFFF_FFFF, 32'd16,        5'd14, 32'd15,        34, 1'b1, s); wait_idle();
    issue(F3_DIV,    32'h8000_0000, 32'd2,         5'd15, 32'hC000_0000, 34, 1'b1, s); wait_idle();
    issue(F3_DIVU,   32'd100,       32'd0,         5'd16, 32'hFFFF_FFFF, 1, 1'b1, s);  wait_idle();
    issue(F3_REMU,   32'd7,         32'd0,         5'd17, 32'd7,         1, 1'b1, s);  wait_idle();
    issue(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0,         1, 1'b1, s);  wait_idle();
    issue(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1, 1'b1, s);  wait_idle();

    // Flush at cycle 10 of a DIVU
    dc = done_count;
    issue(F3_DIVU, 32'd1000, 32'd7, 5'd20, 32'd0, 34, 1'b0, s);
    repeat (9) @(negedge CLK);
    bus.Flush = 1'b1;
    @(negedge CLK);
    bus.Flush = 1'b0;
    #1 chk("flush_busy", 32'(bus.Busy), 32'd0);
    chk("flush_stall", 32'(bus.Stall), 32'd0);
    chk("flush_result", bus.Result, last_res);
    repeat (40) @(negedge CLK);
    chk("flush_no_done", 32'(done_count), 32'(dc));

    // Reset pulse at cycle 10 of a DIVU
    issue(F3_DIVU, 32'd1000, 32'd7, 5'd21, 32'd0, 34, 1'b0, s);
    repeat (9) @(negedge CLK);
    Reset = 1'b0;
    #1 chk("rstmid_result", bus.Result, 32'd0);
    chk("rstmid_waddr", 32'(bus.Out_WriteAddress), 32'd0);
    chk("rstmid_busy", 32'(bus.Busy), 32'd0);
    chk("rstmid_done", 32'(bus.Done), 32'd0);
    chk("rstmid_stall", 32'(bus.Stall), 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
    repeat (40) @(negedge CLK);
    chk("rstmid_no_done", 32'(done_count), 32'(dc));

    // Back-to-back: DIVU 9/2 then MUL 3x4 issued in the DIVU Done cycle
    @(negedge CLK);
    drive(F3_DIVU, 32'd9, 32'd2, 5'd3);
    exp_q.push_back('{32'd4, 5'd3, cyc + 34});
    $display("issue: cycle %0d DIVU 9/2 rd 3", cyc);
    #1 chk("b2b_stall_c0", 32'(bus.Stall), 32'd1);
    for (int i = 1; i <= 36; i++) begin
      @(negedge CLK);
      if (i == 1 || i == 35) bus.Start = 1'b0;
      if (i == 34) begin
        drive(F3_MUL, 32'd3, 32'd4, 5'd4);
        exp_q.push_back('{32'd12, 5'd4, cyc + 2});
        $display("issue: cycle %0d MUL 3x4 rd 4", cyc);
      end
      #1 chk("b2b_stall", 32'(bus.Stall), (i == 36) ? 32'd0 : 32'd1);
    end
    wait_idle();
    chk("done_total", 32'(done_count), 32'(dc + 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
